// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: round-robin read-request arbiter and
// owner-tag return router for the DDR controller read port.
module ddr_rd_arbiter #(
  parameter int CLIENTS = 4,
  parameter int OWNERS  = 2,
  parameter int UADDR   = 23,
  parameter int UWIDTH  = 32
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [CLIENTS-1:0]       cl_req_i,
  input  logic [CLIENTS-1:0]       cl_block_i,
  input  logic [CLIENTS*UADDR-1:0] cl_addr_i,
  output logic [CLIENTS-1:0]       cl_ack_o,
  output logic [CLIENTS-1:0]       cl_ready_o,
  output logic [UWIDTH-1:0]        cl_data_o,
  output logic                     rd_req_o,
  output logic                     rd_block_o,
  output logic [OWNERS-1:0]        rd_owner_o,
  output logic [UADDR-1:0]         rd_addr_o,
  input  logic                     rd_busy_i,
  input  logic                     rd_ready_i,
  input  logic [OWNERS-1:0]        rd_owner_i,
  input  logic [UWIDTH-1:0]        rd_data_i
);

  logic [OWNERS-1:0]  r_last;
  logic               r_req;
  logic               r_blk;
  logic [OWNERS-1:0]  r_owner;
  logic [UADDR-1:0]   r_addr;
  logic [CLIENTS-1:0] r_ack;
  logic [CLIENTS-1:0] r_rdy;
  logic [UWIDTH-1:0]  r_data;

  logic [CLIENTS-1:0] w_elig;
  logic               w_found;
  logic               w_go;
  logic [OWNERS-1:0]  w_gnt;
  logic [CLIENTS-1:0] w_oh;
  logic [UADDR-1:0]   w_addr;
  logic               w_blk;
  logic [CLIENTS-1:0] w_rdy;
  int                 w_pos;

  // the client just acked is masked so its held request is not issued twice
  assign w_elig = cl_req_i & ~r_ack;
  assign w_go   = w_found & ~rd_busy_i;

  // round-robin search starting after the last grant, wrapping at CLIENTS
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_oh    = '0;
    w_addr  = '0;
    w_blk   = 1'b0;
    w_pos   = 0;
    for (int i = 1; i <= CLIENTS; i++) begin
      w_pos = (int'(r_last) + i) % CLIENTS;
      for (int k = 0; k < CLIENTS; k++) begin
        if (!w_found && w_pos == k && w_elig[k]) begin
          w_found = 1'b1;
          w_gnt   = OWNERS'(k);
          w_oh[k] = 1'b1;
          w_addr  = cl_addr_i[k*UADDR +: UADDR];
          w_blk   = cl_block_i[k];
        end
      end
    end
  end

  // decode the return tag; tags beyond the last client match nothing
  always_comb begin
    w_rdy = '0;
    for (int k = 0; k < CLIENTS; k++) begin
      w_rdy[k] = rd_ready_i && (rd_owner_i == OWNERS'(k));
    end
  end

  // issue path: register the granted request and advance the pointer
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_last  <= OWNERS'(CLIENTS - 1);
      r_req   <= 1'b0;
      r_blk   <= 1'b0;
      r_owner <= '0;
      r_addr  <= '0;
      r_ack   <= '0;
    end else begin
      r_req <= w_go;
      r_ack <= w_go ? w_oh : '0;
      if (w_go) begin
        r_owner <= w_gnt;
        r_addr  <= w_addr;
        r_blk   <= w_blk;
        r_last  <= w_gnt;
      end
    end
  end

  // return path: route returned word to its owner one cycle later
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_rdy  <= '0;
      r_data <= '0;
    end else begin
      r_rdy <= w_rdy;
      if (rd_ready_i) begin
        r_data <= rd_data_i;
      end
    end
  end

  assign rd_req_o   = r_req;
  assign rd_block_o = r_blk;
  assign rd_owner_o = r_owner;
  assign rd_addr_o  = r_addr;
  assign cl_ack_o   = r_ack;
  assign cl_ready_o = r_rdy;
  assign cl_data_o  = r_data;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: scoreboard bench for ddr_rd_arbiter,
// issue and return streams checked by a negedge monitor.
module tb_ddr_rd_arbiter;

  logic        clk;
  logic        reset_i;
  logic [3:0]  cl_req;
  logic [3:0]  cl_block;
  logic [91:0] cl_addr;
  logic [3:0]  cl_ack;
  logic [3:0]  cl_ready;
  logic [31:0] cl_data;
  logic        rd_req;
  logic        rd_block;
  logic [1:0]  rd_owner;
  logic [22:0] rd_addr;
  logic        rd_busy;
  logic        rd_ready;
  logic [1:0]  rd_owner_in;
  logic [31:0] rd_data;

  logic [2:0]  d3_ack;
  logic [2:0]  d3_ready;
  logic [31:0] d3_data;
  logic        d3_req;
  logic        d3_block;
  logic [1:0]  d3_owner;
  logic [22:0] d3_addr;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [1:0]  own;
    logic [22:0] addr;
    logic        blk;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [3:0]  mask;
    logic [31:0] data;
  } ret_t;

  iss_t iq[$];
  ret_t rq[$];

  ddr_rd_arbiter dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .cl_req_i   (cl_req),
    .cl_block_i (cl_block),
    .cl_addr_i  (cl_addr),
    .cl_ack_o   (cl_ack),
    .cl_ready_o (cl_ready),
    .cl_data_o  (cl_data),
    .rd_req_o   (rd_req),
    .rd_block_o (rd_block),
    .rd_owner_o (rd_owner),
    .rd_addr_o  (rd_addr),
    .rd_busy_i  (rd_busy),
    .rd_ready_i (rd_ready),
    .rd_owner_i (rd_owner_in),
    .rd_data_i  (rd_data)
  );

  ddr_rd_arbiter #(.CLIENTS(3)) dut3 (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .cl_req_i   (3'b000),
    .cl_block_i (3'b000),
    .cl_addr_i  (69'd0),
    .cl_ack_o   (d3_ack),
    .cl_ready_o (d3_ready),
    .cl_data_o  (d3_data),
    .rd_req_o   (d3_req),
    .rd_block_o (d3_block),
    .rd_owner_o (d3_owner),
    .rd_addr_o  (d3_addr),
    .rd_busy_i  (1'b0),
    .rd_ready_i (rd_ready),
    .rd_owner_i (rd_owner_in),
    .rd_data_i  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [22:0] a);
    cl_addr[k*23 +: 23] = a;
  endtask

  task automatic push_iss(input int c, input int o,
                          input logic [22:0] a, input logic b);
    iss_t e;
    e.cyc  = c;
    e.own  = 2'(o);
    e.addr = a;
    e.blk  = b;
    iq.push_back(e);
  endtask

  task automatic push_ret(input int c, input logic [3:0] m,
                          input logic [31:0] d);
    ret_t e;
    e.cyc  = c;
    e.mask = m;
    e.data = d;
    rq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset_i) begin
      if (rd_req) begin
        if (iq.size() == 0) begin
          chk("unexpected_issue", 64'(rd_owner), 64'hdead);
        end else begin
          iss_t e;
          e = iq.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("issue_owner", 64'(rd_owner), 64'(e.own));
          chk("issue_addr", 64'(rd_addr), 64'(e.addr));
          chk("issue_block", 64'(rd_block), 64'(e.blk));
          chk("issue_ack", 64'(cl_ack), 64'(4'b0001 << e.own));
        end
      end else if (cl_ack != 4'b0000) begin
        chk("ack_without_issue", 64'(cl_ack), 64'h0);
      end
      if (cl_ready != 4'b0000) begin
        if (rq.size() == 0) begin
          chk("unexpected_ready", 64'(cl_ready), 64'h0);
        end else begin
          ret_t r;
          r = rq.pop_front();
          chk("ret_cycle", 64'(cyc), 64'(r.cyc));
          chk("ret_mask", 64'(cl_ready), 64'(r.mask));
          chk("ret_data", 64'(cl_data), 64'(r.data));
        end
      end
    end
  end

  initial begin
    int c;
    reset_i     = 1'b1;
    cl_req      = '0;
    cl_block    = '0;
    cl_addr     = '0;
    rd_busy     = 1'b0;
    rd_ready    = 1'b0;
    rd_owner_in = '0;
    rd_data     = '0;
    repeat (3) tick;
    chk("rst_rd_req", 64'(rd_req), 64'h0);
    chk("rst_rd_block", 64'(rd_block), 64'h0);
    chk("rst_rd_owner", 64'(rd_owner), 64'h0);
    chk("rst_rd_addr", 64'(rd_addr), 64'h0);
    chk("rst_cl_ack", 64'(cl_ack), 64'h0);
    chk("rst_cl_ready", 64'(cl_ready), 64'h0);
    chk("rst_cl_data", 64'(cl_data), 64'h0);
    reset_i = 1'b0;
    repeat (3) tick;
    chk("idle_rd_req", 64'(rd_req), 64'h0);
    chk("idle_cl_ack", 64'(cl_ack), 64'h0);

    // all four request continuously
    for (int k = 0; k < 4; k++) set_addr(k, 23'h100 + 23'(k));
    cl_block = 4'b0101;
    cl_req   = 4'b1111;
    c = cyc;
    for (int k = 0; k < 8; k++) begin
      push_iss(c + 1 + k, k % 4, 23'h100 + 23'(k % 4), (k % 2) == 0);
    end
    repeat (8) tick;
    cl_req = '0;
    repeat (2) tick;

    // busy for five cycles while clients 1 and 3 request
    cl_block = 4'b0000;
    rd_busy  = 1'b1;
    cl_req   = 4'b1010;
    c = cyc;
    push_iss(c + 6, 1, 23'h101, 1'b0);
    push_iss(c + 7, 3, 23'h103, 1'b0);
    repeat (5) tick;
    rd_busy = 1'b0;
    repeat (2) tick;
    cl_req = '0;
    repeat (2) tick;

    // client 2 alone, every other cycle
    set_addr(2, 23'h12345);
    cl_block = 4'b0100;
    cl_req   = 4'b0100;
    c = cyc;
    for (int k = 0; k < 4; k++) push_iss(c + 1 + 2*k, 2, 23'h12345, 1'b1);
    repeat (8) tick;
    cl_req = '0;
    repeat (2) tick;

    // return path with concurrent issue from client 0
    cl_block    = 4'b0000;
    cl_req      = 4'b0001;
    c = cyc;
    push_iss(c + 1, 0, 23'h100, 1'b0);
    push_iss(c + 3, 0, 23'h100, 1'b0);
    push_ret(c + 1, 4'b1000, 32'hA5A5A5A5);
    push_ret(c + 2, 4'b0001, 32'h00000001);
    push_ret(c + 3, 4'b0010, 32'hFFFFFFFF);
    rd_ready    = 1'b1;
    rd_owner_in = 2'd3;
    rd_data     = 32'hA5A5A5A5;
    tick;
    chk("c3_owner3_drop", 64'(d3_ready), 64'h0);
    rd_owner_in = 2'd0;
    rd_data     = 32'h00000001;
    tick;
    chk("c3_owner0_ready", 64'(d3_ready), 64'h1);
    rd_owner_in = 2'd1;
    rd_data     = 32'hFFFFFFFF;
    tick;
    rd_ready = 1'b0;
    cl_req   = '0;
    tick;
    chk("ret_idle_ready", 64'(cl_ready), 64'h0);
    chk("ret_data_hold", 64'(cl_data), 64'hFFFFFFFF);
    tick;

    // async reset in the cycle a grant is made
    cl_block = 4'b1000;
    cl_req   = 4'b1001;
    @(posedge clk);
    #1;
    chk("pre_rst_req", 64'(rd_req), 64'h1);
    chk("pre_rst_owner", 64'(rd_owner), 64'h3);
    #1;
    reset_i = 1'b1;
    #1;
    chk("async_rd_req", 64'(rd_req), 64'h0);
    chk("async_cl_ack", 64'(cl_ack), 64'h0);
    chk("async_rd_addr", 64'(rd_addr), 64'h0);
    chk("async_rd_owner", 64'(rd_owner), 64'h0);
    tick;
    tick;
    reset_i = 1'b0;
    c = cyc;
    push_iss(c + 1, 0, 23'h100, 1'b0);
    push_iss(c + 2, 3, 23'h103, 1'b1);
    repeat (2) tick;
    cl_req = '0;
    repeat (3) tick;

    chk("issue_queue_empty", 64'(iq.size()), 64'h0);
    chk("ret_queue_empty", 64'(rq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_rd_arbiter.md
# ddr_rd_arbiter

Round-robin arbiter and return router for the read port of the DDR memory controller. It collects single-word and block read requests from up to `CLIENTS` bus masters and issues them one at a time into the controller's read request interface (`rd_req`/`rd_block`/`rd_owner`/`rd_addr`), honouring `rd_busy`. It demultiplexes returned read data back to the requesting client using the owner tag.

## Interface
Parameters:
- `CLIENTS`, 4: number of read clients; must satisfy 2 ≤ `CLIENTS` ≤ 2^`OWNERS`.
- `OWNERS`, 2: owner tag width; the tag is the client index.
- `UADDR`, 23: user address width.
- `UWIDTH`, 32: read data width.

Ports (one clock; reset is asynchronous and active-high):
- `clock_i`, in, 1: system clock; all state changes on its rising edge.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `cl_req_i`, in, `CLIENTS`: per-client read request; held until acked.
- `cl_block_i`, in, `CLIENTS`: per-client block (whole-row) qualifier.
- `cl_addr_i`, in, `CLIENTS*UADDR`: client k's address is bits `[k*UADDR +: UADDR]`.
- `cl_ack_o`, out, `CLIENTS`: one-hot, one-cycle acknowledge; the request has been issued.
- `cl_ready_o`, out, `CLIENTS`: one-hot, one-cycle return-data valid.
- `cl_data_o`, out, `UWIDTH`: return data, shared by all clients.
- `rd_req_o`, out, 1: request strobe to the controller.
- `rd_block_o`, out, 1: block qualifier to the controller.
- `rd_owner_o`, out, `OWNERS`: tag equal to the granted client index.
- `rd_addr_o`, out, `UADDR`: address to the controller.
- `rd_busy_i`, in, 1: controller read queue cannot accept a further request after the current one.
- `rd_ready_i`, in, 1: return data valid from the controller.
- `rd_owner_i`, in, `OWNERS`: tag of the returned data.
- `rd_data_i`, in, `UWIDTH`: returned data.

## Operation
- State: `last` is an `OWNERS`-bit pointer to the most recently granted client, reset to `CLIENTS-1`, so client 0 has first priority. All outputs are registered.
- Eligibility in cycle N: client k is eligible if `cl_req_i[k]` is high and `cl_ack_o[k]` is low. Masking the client just acked prevents its still-high request from being issued twice.
- Grant in cycle N:
  - Condition: `rd_busy_i` is low and at least one client is eligible.
  - Selection: the first eligible client searching `last+1, last+2, …` modulo `CLIENTS`.
  - Wrap-around: the search from `last = CLIENTS-1` begins at 0. Pointer arithmetic wraps at `CLIENTS`, not at 2^`OWNERS`.
- Issue in cycle N+1 for grant g:
  - `rd_req_o` = 1, `rd_owner_o` = g, `rd_addr_o` = client g's address, `rd_block_o` = `cl_block_i[g]`, all as sampled in cycle N.
  - `cl_ack_o[g]` = 1.
  - `last` becomes g.
- No grant: when there is no grant, `rd_req_o` and `cl_ack_o` are 0 in the following cycle. `rd_addr_o`, `rd_owner_o` and `rd_block_o` hold their previous values. `last` is unchanged.
- Busy: the controller asserts `rd_busy_i` with at least one free entry. The arbiter therefore never issues in the cycle after `rd_busy_i` was high, and one in-flight issue is always absorbed.
- Re-request: a client keeping `cl_req_i` high after its ack presents a new request. It is eligible again from the cycle after the ack.
- Return path: in cycle N+1 after `rd_ready_i` is high in cycle N:
  - `cl_ready_o` = one-hot(`rd_owner_i`) and `cl_data_o` = `rd_data_i`.
  - If `rd_owner_i` ≥ `CLIENTS`, `cl_ready_o` = 0 and the word is dropped.
  - When `rd_ready_i` is low, `cl_ready_o` = 0 and `cl_data_o` holds.
- Independence: the issue and return paths are independent and may be active in the same cycle.
- Reset values: `rd_req_o` = 0, `rd_block_o` = 0, `rd_owner_o` = 0, `rd_addr_o` = 0, `cl_ack_o` = 0, `cl_ready_o` = 0, `cl_data_o` = 0, `last` = `CLIENTS-1`.
- Reset mid-operation: a pending issue or return is discarded immediately. The client's request stays unacked and is re-arbitrated after reset is released.

## Timing
- Request-to-issue latency is one cycle: `cl_req_i` high and `rd_busy_i` low in cycle N gives `rd_req_o` and `cl_ack_o` high in N+1.
- Peak issue rate is one request per cycle across clients. A single client alone achieves one request every two cycles because of the ack mask.
- Return latency is one cycle from `rd_ready_i` to `cl_ready_o`.
- Fairness: under continuous contention, each of n requesting clients is granted exactly once in every n grants.

## Test plan
- Reset held, then released with no requests -> all outputs stay 0 and the first grant goes to client 0 when all four request.
- All four clients request continuously, `rd_busy_i` = 0 -> `rd_owner_o` sequence is 0,1,2,3,0,… with `rd_req_o` high every cycle and each ack in the same cycle as its issue.
- Client 2 alone holds `cl_req_i` with addr 0x12345 and block = 1 -> `rd_req_o` pulses every other cycle with `rd_addr_o` = 0x12345, `rd_block_o` = 1, `rd_owner_o` = 2.
- `rd_busy_i` high for 5 cycles while clients 1 and 3 request -> no `rd_req_o` during the 5 cycles plus one, then 1 is issued before 3 with nothing dropped or duplicated.
- `rd_ready_i` with owners 3,0,1 and data 0xA5A5A5A5, 0x1, 0xFFFFFFFF -> `cl_ready_o` = 1000, 0001, 0010 one cycle later with matching `cl_data_o`; owner 3 with `CLIENTS` = 3 -> `cl_ready_o` = 0.
- Assert `reset_i` asynchronously in the same cycle a grant is made -> outputs clear without waiting for a clock edge, no ack is seen, and the request is issued again after release with `last` reset so client 0 has priority.
